parallel_adder: RTL and testbench

//   WIDTH-bit ripple-carry parallel adder: Sum = A + B + Cin, with carry-out and signed overflow.

---
 rtl/adder_pkg.sv | 8 +
 rtl/full_adder.sv | 16 +
 rtl/parallel_adder.sv | 74 +++++++
 tb/tb_parallel_adder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and types for the ripple-carry parallel adder.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef logic [DEF_WIDTH-1:0] sum_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; one instance per bit of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/parallel_adder.sv
// WIDTH-bit ripple-carry adder with combinational result ports and an optional
// one-cycle registered copy qualified by out_valid.
module parallel_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             out_valid_d;
    logic             out_valid_q;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (Sum[i]),
            .co (carry[i+1])
        );
    end

    assign Cout     = carry[WIDTH];
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign Overflow = carry[WIDTH] ^ carry[WIDTH-1];

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d  = Sum;
            cout_d = Cout;
            ovf_d  = Overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_parallel_adder.sv
// Self-checking bench for parallel_adder: directed vectors plus random traffic,
// with a queue holding the expected registered outputs for the following edge.
module tb_parallel_adder;
    import adder_pkg::*;

    typedef struct packed {
        logic vld;
        logic ovf;
        logic cout;
        sum_t sum;
    } reg_exp_t;

    logic clk;
    logic rst;
    sum_t A;
    sum_t B;
    logic Cin;
    logic in_valid;
    sum_t Sum;
    logic Cout;
    logic Overflow;
    sum_t sum_q;
    logic cout_q;
    logic ovf_q;
    logic out_valid;

    int checks;
    int errors;

    reg_exp_t model_q;
    reg_exp_t sb[$];

    parallel_adder #(
        .WIDTH (DEF_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational result, then check
    // the registered outputs after the next rising edge.
    task automatic apply(input sum_t a, input sum_t b, input logic ci, input logic v,
                         input logic r, input sum_t es, input logic ec, input logic eo);
        reg_exp_t got;
        reg_exp_t want;
        A        = a;
        B        = b;
        Cin      = ci;
        in_valid = v;
        rst      = r;
        #1;
        check("sum", 32'(Sum), 32'(es));
        check("cout", 32'(Cout), 32'(ec));
        check("ovf", 32'(Overflow), 32'(eo));
        if (r) begin
            model_q = '0;
        end else begin
            model_q.vld = v;
            if (v) begin
                model_q.sum  = es;
                model_q.cout = ec;
                model_q.ovf  = eo;
            end
        end
        sb.push_back(model_q);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = '{vld: out_valid, ovf: ovf_q, cout: cout_q, sum: sum_q};
        check("sum_q", 32'(got.sum), 32'(want.sum));
        check("cout_q", 32'(got.cout), 32'(want.cout));
        check("ovf_q", 32'(got.ovf), 32'(want.ovf));
        check("out_valid", 32'(got.vld), 32'(want.vld));
    endtask

    initial begin
        logic [DEF_WIDTH:0] full;
        sum_t ra;
        sum_t rb;
        logic rc;
        logic rv;
        logic rr;
        logic ro;

        checks   = 0;
        errors   = 0;
        model_q  = '0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b1;

        // Reset for two cycles, combinational path still live.
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);

        // Directed vectors.
        apply(8'h6A, 8'hDB, 1'b0, 1'b1, 1'b0, 8'h45, 1'b1, 1'b0);
        apply(8'hAA, 8'h33, 1'b0, 1'b1, 1'b0, 8'hDD, 1'b0, 1'b0);
        apply(8'hAA, 8'h33, 1'b1, 1'b1, 1'b0, 8'hDE, 1'b0, 1'b0);
        apply(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        apply(8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        apply(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Registered path: load, hold, then reset mid-stream.
        apply(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        apply(8'h05, 8'h06, 1'b0, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0);
        apply(8'h05, 8'h06, 1'b0, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0);
        apply(8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
        apply(8'h7F, 8'h7F, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);

        // Random traffic against an independent arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            ra   = sum_t'($urandom);
            rb   = sum_t'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rv   = ($urandom_range(0, 3) != 0);
            rr   = ($urandom_range(0, 49) == 0);
            full = {1'b0, ra} + {1'b0, rb} + {{DEF_WIDTH{1'b0}}, rc};
            ro   = (ra[DEF_WIDTH-1] == rb[DEF_WIDTH-1]) &&
                   (full[DEF_WIDTH-1] != ra[DEF_WIDTH-1]);
            apply(ra, rb, rc, rv, rr, full[DEF_WIDTH-1:0], full[DEF_WIDTH], ro);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
